// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage sequencer.
package pipe_pkg;

    localparam int PIPE_MAX_STAGES = 16;

    // Bits needed to count 0..stages valid stages.
    function automatic int pipe_cnt_w(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One stage of the valid chain: holds a valid bit, forms its advance
// term from the stage ahead, and gates the datapath load enable.
module pipe_stage_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic adv_next,
    input  logic flush,
    output logic v,
    output logic adv,
    output logic en
);

    // An empty stage can always take a beat, which closes bubbles.
    assign adv = !v | adv_next;
    assign en  = adv & src & !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            v <= 1'b0;
        end else if (adv) begin
            v <= src;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Sequencer for a chain of enable-gated datapath registers: valid
// tracking, bubble collapse, backpressure, flush and occupancy.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int CNT_W  = pipe_cnt_w(STAGES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  occupancy,
    output logic              idle
);

    if (STAGES < 1 || STAGES > PIPE_MAX_STAGES) begin : g_bad_stages
        $error("pipe_stage_ctrl: STAGES out of range");
    end

    // Reset and flush both discard everything and block handshakes.
    logic kill;
    assign kill = flush | !rst_n;

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] adv_nx;
    logic [STAGES-1:0] src;

    for (genvar i = 0; i < STAGES; i++) begin : g_cell
        if (i == STAGES - 1) begin : g_last
            assign adv_nx[i] = out_ready;
        end else begin : g_mid
            assign adv_nx[i] = adv[i+1];
        end

        if (i == 0) begin : g_first
            assign src[i] = in_valid;
        end else begin : g_rest
            assign src[i] = stage_valid[i-1];
        end

        pipe_stage_cell u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .src      (src[i]),
            .adv_next (adv_nx[i]),
            .flush    (kill),
            .v        (stage_valid[i]),
            .adv      (adv[i]),
            .en       (stage_en[i])
        );
    end

    assign in_ready  = adv[0] & !kill;
    assign out_valid = stage_valid[STAGES-1] & !kill;

    logic in_fire;
    logic out_fire;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (kill) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + CNT_W'(in_fire) - CNT_W'(out_fire);
        end
    end

    assign idle = !rst_n | (occupancy == '0);

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Randomized bench for pipe_stage_ctrl against a slot-queue model
// with an external datapath carrying beat ids.
module tb_pipe_stage_ctrl;

    localparam int S  = 4;
    localparam int CW = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [S-1:0]  stage_en;
    logic [S-1:0]  stage_valid;
    logic [CW-1:0] occupancy;
    logic          idle;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(.STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .occupancy   (occupancy),
        .idle        (idle)
    );

    // Datapath registers, loaded only by the DUT enables.
    logic [31:0] in_data;
    logic [31:0] dp [S];

    always_ff @(posedge clk) begin
        for (int i = 0; i < S; i++) begin
            if (stage_en[i]) begin
                dp[i] <= (i == 0) ? in_data : dp[i-1];
            end
        end
    end

    int unsigned ncheck = 0;
    int unsigned npass  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncheck++;
        if (got === exp) begin
            npass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    // Model: slot[i] holds a beat id or -1; q holds ids in flight.
    int          slot [S];
    int          q [$];
    int          next_id = 1;
    int          cycno = 0;

    logic         obs_ir;
    logic         obs_ov;
    logic [S-1:0] obs_en;
    logic [S-1:0] obs_sv;
    int           obs_occ;
    int           obs_cyc;

    task automatic cyc(input logic r, input logic iv, input logic ordy,
                       input logic fl);
        int           g;
        int           cnt;
        logic         kill;
        logic [S-1:0] een;
        logic [S-1:0] vb;
        logic         acc;
        @(negedge clk);
        rst_n     = r;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = next_id;
        #1;
        kill = fl | !r;
        // Under a stall, the full run of slots nearest the output holds.
        g = S;
        if (!ordy) begin
            while (g > 0 && slot[g-1] >= 0) g--;
        end
        cnt = 0;
        vb  = '0;
        een = '0;
        for (int i = 0; i < S; i++) begin
            if (slot[i] >= 0) begin
                cnt++;
                vb[i] = 1'b1;
            end
            if (i < g && !kill) begin
                een[i] = (i == 0) ? iv : (slot[i-1] >= 0);
            end
        end
        acc = iv && g > 0 && !kill;
        chk("in_ready", 32'(in_ready), 32'(g > 0 && !kill));
        chk("out_valid", 32'(out_valid), 32'(slot[S-1] >= 0 && !kill));
        chk("stage_en", 32'(stage_en), 32'(een));
        chk("stage_valid", 32'(stage_valid), 32'(vb));
        chk("occupancy", 32'(occupancy), 32'(cnt));
        chk("idle", 32'(idle), 32'(!r || cnt == 0));
        chk("popcount", 32'(occupancy), 32'($countones(stage_valid)));
        if (!kill && ordy && slot[S-1] >= 0) begin
            if (q.size() == 0) begin
                chk("out_order", dp[S-1], 32'hFFFF_FFFF);
            end else begin
                chk("out_order", dp[S-1], 32'(q[0]));
                void'(q.pop_front());
            end
        end
        obs_ir  = in_ready;
        obs_ov  = out_valid;
        obs_en  = stage_en;
        obs_sv  = stage_valid;
        obs_occ = int'(occupancy);
        obs_cyc = cycno;
        @(posedge clk);
        if (kill) begin
            for (int i = 0; i < S; i++) slot[i] = -1;
            q.delete();
        end else begin
            for (int i = S - 1; i >= 0; i--) begin
                if (i < g) begin
                    if (i == 0) slot[i] = iv ? next_id : -1;
                    else        slot[i] = slot[i-1];
                end
            end
            if (acc) begin
                q.push_back(next_id);
                next_id++;
            end
        end
        cycno++;
    endtask

    int t0;
    int first_ov;
    int nfire;
    int peak;

    initial begin
        for (int i = 0; i < S; i++) slot[i] = -1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_in_ready", 32'(obs_ir), 32'd0);
        chk("rst_out_valid", 32'(obs_ov), 32'd0);
        chk("rst_stage_en", 32'(obs_en), 32'd0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_in_ready", 32'(obs_ir), 32'd1);
        chk("post_rst_occ", 32'(obs_occ), 32'd0);

        // Streaming: 8 beats back to back with the output open.
        t0 = cycno;
        first_ov = -1;
        nfire = 0;
        peak = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, k < 8, 1'b1, 1'b0);
            if (obs_ov) begin
                nfire++;
                if (first_ov < 0) first_ov = obs_cyc - t0;
            end
            if (obs_occ > peak) peak = obs_occ;
        end
        chk("stream_latency", 32'(first_ov), 32'(S));
        chk("stream_fires", 32'(nfire), 32'd8);
        chk("stream_peak", 32'(peak), 32'(S));

        // Backpressure fill, then release while full.
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_in_ready", 32'(obs_ir), 32'd0);
        chk("full_occ", 32'(obs_occ), 32'(S));
        chk("full_en", 32'(obs_en), 32'd0);
        chk("full_out_valid", 32'(obs_ov), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("release_in_ready", 32'(obs_ir), 32'd1);
        chk("release_en", 32'(obs_en), 32'(4'hF));

        // Bubble collapse with the output stalled.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) cyc(1'b1, (k % 2) == 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bubble_sv", 32'(obs_sv), 32'(4'hF));

        // Flush at occupancy 3 with input pending.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_occ_before", 32'(obs_occ), 32'd3);
        chk("flush_in_ready", 32'(obs_ir), 32'd0);
        chk("flush_out_valid", 32'(obs_ov), 32'd0);
        chk("flush_en", 32'(obs_en), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("after_flush_sv", 32'(obs_sv), 32'd0);
        chk("after_flush_occ", 32'(obs_occ), 32'd0);
        chk("after_flush_ready", 32'(obs_ir), 32'd1);
        chk("after_flush_ov", 32'(obs_ov), 32'd0);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 10000; k++) begin
            cyc($urandom_range(199) != 0,
                $urandom_range(99) < 60,
                $urandom_range(99) < 60,
                $urandom_range(99) < 4);
        end

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
